m32_uart_io_responder: RTL and testbench

- Memory-mapped UART peripheral that answers integer-core loads and stores in I/O space (0xA0000000–0xBFFFFFFF).
- Sits on the core's I/O strobes: `maddr`, `data2mem`, active-low `ioWr`/`ioRd`. It returns read data combinationally so the single-cycle core can capture it in the same cycle.
- Contains a TX FIFO with an 8N1 serializer, and an RX deserializer with an RX FIFO.
- Provides status, sticky error flags and a programmable baud divider.

---
 rtl/m32_uart_io_responder_if.sv | 12 +
 rtl/m32_uart_io_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_m32_uart_io_responder.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/m32_uart_io_responder_if.sv
// Core I/O strobe bundle: the core drives address, store data and the active-low
// strobes; the responder answers with combinational read data.
interface m32_uart_io_responder_if;
  logic [31:0] maddr;
  logic [31:0] data2mem;
  logic        ioWr;
  logic        ioRd;
  logic [31:0] io_rdata;

  modport master (output maddr, data2mem, ioWr, ioRd, input io_rdata);
  modport slave  (input maddr, data2mem, ioWr, ioRd, output io_rdata);
endinterface

// File: rtl/m32_uart_io_responder.sv
// Memory-mapped 8N1 UART: TX FIFO + serializer, RX deserializer + FIFO, sticky flags.
// TX: IDLE wait for FIFO | START line low | DATA head byte lsb-first | STOP line high
// RX: IDLE wait falling | START mid-bit check | DATA 8 samples | STOP sample, or wait high after frame error
module m32_uart_io_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'hA000_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic                          coreClk,
  input  logic                          coreRst,
  m32_uart_io_responder_if.slave        bus,
  input  logic                          uart_rx,
  output logic                          uart_tx,
  output logic                          irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic sel, wr, rd;
  logic [1:0] idx;
  logic [15:0] div;
  logic ovr_flag, ferr_flag, txovf_flag;
  logic unused_bits;

  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_cnt;
  logic tx_push_req, tx_push, tx_pop;
  tx_state_t tx_state, tx_state_nxt;
  logic [15:0] tx_bcnt, tx_bcnt_nxt, tx_div, tx_div_nxt;
  logic [2:0] tx_bit, tx_bit_nxt;
  logic tx_bit_end;

  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_cnt;
  logic rx_push_req, rx_push, rx_pop, ferr_set;
  rx_state_t rx_state, rx_state_nxt;
  logic [15:0] rx_bcnt, rx_bcnt_nxt, rx_div, rx_div_nxt;
  logic [2:0] rx_bit, rx_bit_nxt;
  logic [7:0] rx_shift, rx_shift_nxt;
  logic rx_brk, rx_brk_nxt;
  logic rx_s1, rx_s2, rx_s3;

  assign sel = (bus.maddr[31:4] == BASE_ADDR[31:4]);
  assign idx = bus.maddr[3:2];
  assign wr  = sel & ~bus.ioWr;
  // a simultaneous write suppresses the read side effect
  assign rd  = sel & ~bus.ioRd & bus.ioWr;
  assign unused_bits = ^{bus.data2mem[31:16], bus.maddr[1:0]};

  assign tx_push_req = wr && (idx == 2'd0);
  assign tx_bit_end  = (tx_bcnt == tx_div - 16'd1);
  assign tx_pop      = (tx_state == TX_STOP) && tx_bit_end;
  assign tx_push     = tx_push_req && ((tx_cnt != FULL_CNT) || tx_pop);

  assign rx_pop  = rd && (idx == 2'd1) && (rx_cnt != '0);
  assign rx_push = rx_push_req && ((rx_cnt != FULL_CNT) || rx_pop);
  assign irq     = (rx_cnt != '0);

  always_comb begin
    tx_state_nxt = tx_state;
    tx_bcnt_nxt  = tx_bcnt + 16'd1;
    tx_bit_nxt   = tx_bit;
    tx_div_nxt   = tx_div;
    case (tx_state)
      TX_IDLE: begin
        tx_bcnt_nxt = '0;
        if (tx_cnt != '0) begin
          tx_state_nxt = TX_START;
          tx_div_nxt   = div;
        end
      end
      TX_START: if (tx_bit_end) begin
        tx_state_nxt = TX_DATA;
        tx_bcnt_nxt  = '0;
        tx_bit_nxt   = '0;
      end
      TX_DATA: if (tx_bit_end) begin
        tx_bcnt_nxt = '0;
        if (tx_bit == 3'd7) tx_state_nxt = TX_STOP;
        else                tx_bit_nxt   = tx_bit + 3'd1;
      end
      TX_STOP: if (tx_bit_end) begin
        tx_bcnt_nxt = '0;
        if ((tx_cnt > CW'(1)) || tx_push) begin
          tx_state_nxt = TX_START;
          tx_div_nxt   = div;
        end else begin
          tx_state_nxt = TX_IDLE;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // the head entry stays in the FIFO until its stop bit completes
  always_comb begin
    uart_tx = 1'b1;
    if (tx_state == TX_START)     uart_tx = 1'b0;
    else if (tx_state == TX_DATA) uart_tx = tx_mem[tx_rp][tx_bit];
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_bcnt_nxt  = rx_bcnt + 16'd1;
    rx_bit_nxt   = rx_bit;
    rx_div_nxt   = rx_div;
    rx_shift_nxt = rx_shift;
    rx_brk_nxt   = rx_brk;
    rx_push_req  = 1'b0;
    ferr_set     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_bcnt_nxt = '0;
        if (rx_s3 && !rx_s2) begin
          rx_state_nxt = RX_START;
          rx_div_nxt   = div;
        end
      end
      RX_START: if (rx_bcnt == (rx_div >> 1) - 16'd1) begin
        rx_bcnt_nxt  = '0;
        rx_bit_nxt   = '0;
        rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_bcnt == rx_div - 16'd1) begin
        rx_bcnt_nxt  = '0;
        rx_shift_nxt = {rx_s2, rx_shift[7:1]};
        if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
        else                rx_bit_nxt   = rx_bit + 3'd1;
      end
      RX_STOP: begin
        if (rx_brk) begin
          rx_bcnt_nxt = '0;
          if (rx_s2) begin
            rx_state_nxt = RX_IDLE;
            rx_brk_nxt   = 1'b0;
          end
        end else if (rx_bcnt == rx_div - 16'd1) begin
          rx_bcnt_nxt = '0;
          if (rx_s2) begin
            rx_push_req  = 1'b1;
            rx_state_nxt = RX_IDLE;
          end else begin
            ferr_set   = 1'b1;
            rx_brk_nxt = 1'b1;
          end
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge coreClk) begin
    if (tx_push) tx_mem[tx_wp] <= bus.data2mem[7:0];
    if (rx_push) rx_mem[rx_wp] <= rx_shift;
  end

  always_ff @(posedge coreClk) begin
    if (coreRst) begin
      tx_state <= TX_IDLE;
      tx_bcnt  <= '0;
      tx_bit   <= '0;
      tx_div   <= DEFAULT_DIV;
      rx_state <= RX_IDLE;
      rx_bcnt  <= '0;
      rx_bit   <= '0;
      rx_div   <= DEFAULT_DIV;
      rx_shift <= '0;
      rx_brk   <= 1'b0;
      {rx_s1, rx_s2, rx_s3} <= 3'b111;
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
      div <= DEFAULT_DIV;
      ovr_flag <= 1'b0; ferr_flag <= 1'b0; txovf_flag <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      tx_bcnt  <= tx_bcnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_div   <= tx_div_nxt;
      rx_state <= rx_state_nxt;
      rx_bcnt  <= rx_bcnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_div   <= rx_div_nxt;
      rx_shift <= rx_shift_nxt;
      rx_brk   <= rx_brk_nxt;
      {rx_s1, rx_s2, rx_s3} <= {uart_rx, rx_s1, rx_s2};
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + CW'(1);
        2'b01:   tx_cnt <= tx_cnt - CW'(1);
        default: tx_cnt <= tx_cnt;
      endcase
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + CW'(1);
        2'b01:   rx_cnt <= rx_cnt - CW'(1);
        default: rx_cnt <= rx_cnt;
      endcase
      if (wr && (idx == 2'd3))
        div <= (bus.data2mem[15:0] < 16'd2) ? 16'd2 : bus.data2mem[15:0];
      // set beats a same-cycle write-one-to-clear
      ovr_flag   <= (rx_push_req && !rx_push) |
                    (ovr_flag & ~(wr && (idx == 2'd2) && bus.data2mem[3]));
      ferr_flag  <= ferr_set |
                    (ferr_flag & ~(wr && (idx == 2'd2) && bus.data2mem[4]));
      txovf_flag <= (tx_push_req && !tx_push) |
                    (txovf_flag & ~(wr && (idx == 2'd2) && bus.data2mem[5]));
    end
  end

  always_comb begin
    bus.io_rdata = '0;
    if (sel) begin
      case (idx)
        2'd1: if (rx_cnt != '0) bus.io_rdata = {24'b0, rx_mem[rx_rp]};
        2'd2: bus.io_rdata = {26'b0, txovf_flag, ferr_flag, ovr_flag, (rx_cnt != '0),
                              ((tx_cnt == '0) && (tx_state == TX_IDLE)), (tx_cnt == FULL_CNT)};
        2'd3: bus.io_rdata = {16'b0, div};
        default: bus.io_rdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_m32_uart_io_responder.sv
// Randomized bench for the UART responder against a queue-based behavioural model.
module tb_m32_uart_io_responder;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'hA000_0000;
  localparam logic [31:0] A_TX = 32'hA000_0000, A_RX = 32'hA000_0004;
  localparam logic [31:0] A_ST = 32'hA000_0008, A_BD = 32'hA000_000C;

  logic coreClk = 1'b0, coreRst = 1'b1, uart_rx = 1'b1;
  logic uart_tx, irq;
  m32_uart_io_responder_if bus();

  m32_uart_io_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd434)) dut (
    .coreClk(coreClk), .coreRst(coreRst), .bus(bus), .uart_rx(uart_rx),
    .uart_tx(uart_tx), .irq(irq));

  always #5 coreClk = ~coreClk;

  int checks = 0, errors = 0;
  int m_div;
  logic [7:0] m_txq[$], m_rxq[$];
  bit m_ovr, m_ferr, m_txovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_div = 434; m_txq = {}; m_rxq = {};
    m_ovr = 0; m_ferr = 0; m_txovf = 0;
  endfunction

  function automatic logic [31:0] exp_status();
    return {26'b0, m_txovf, m_ferr, m_ovr, m_rxq.size() != 0, m_txq.size() == 0,
            m_txq.size() == DEPTH};
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [31:0] d);
    if (a[31:4] != BASE[31:4]) return;
    case (a[3:2])
      2'd0: if (m_txq.size() < DEPTH) m_txq.push_back(d[7:0]); else m_txovf = 1;
      2'd2: begin
        if (d[3]) m_ovr = 0;
        if (d[4]) m_ferr = 0;
        if (d[5]) m_txovf = 0;
      end
      2'd3: m_div = (d[15:0] < 2) ? 2 : int'(d[15:0]);
      default: ;
    endcase
  endfunction

  function automatic void model_rx(input logic [7:0] b, input bit stop);
    if (!stop) m_ferr = 1;
    else if (m_rxq.size() < DEPTH) m_rxq.push_back(b);
    else m_ovr = 1;
  endfunction

  // all bus tasks start and end on a falling clock edge
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.maddr = a; bus.data2mem = d; bus.ioWr = 1'b0;
    @(negedge coreClk);
    bus.ioWr = 1'b1;
  endtask

  task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
    model_store(a, d);
    bus_write(a, d);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus.maddr = a; bus.ioRd = 1'b0;
    #1 d = bus.io_rdata;
    @(negedge coreClk);
    bus.ioRd = 1'b1;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    bus.maddr = a;
    #1 d = bus.io_rdata;
  endtask

  task automatic rx_read_check(input string tag);
    logic [31:0] d, e;
    bus_read(A_RX, d);
    e = (m_rxq.size() != 0) ? {24'b0, m_rxq.pop_front()} : 32'h0;
    chk(tag, d, e);
  endtask

  task automatic expect_line(input logic [7:0] bytes[$], input int divs[$]);
    logic [9:0] frame;
    for (int f = 0; f < bytes.size(); f++) begin
      frame = {1'b1, bytes[f], 1'b0};
      for (int i = 0; i < 10; i++)
        repeat (divs[f]) begin
          @(negedge coreClk);
          chk("tx_line", {31'b0, uart_tx}, {31'b0, frame[i]});
        end
      if (m_txq.size() != 0) void'(m_txq.pop_front());
    end
  endtask

  task automatic send_serial(input logic [7:0] b, input bit stop, input int d);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (d) @(negedge coreClk);
    end
    uart_rx = 1'b1;
    model_rx(b, stop);
    repeat (4) @(negedge coreClk);
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    peek(A_ST, d);
    chk(tag, d, exp_status());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0] exp_bytes[$];
    int dq[$];
    int n, dv;
    logic [7:0] a, b;

    bus.maddr = '0; bus.data2mem = '0; bus.ioWr = 1'b1; bus.ioRd = 1'b1;
    repeat (3) @(negedge coreClk);
    coreRst = 1'b0;
    model_reset();

    check_status("rst_status");
    chk("rst_status_const", exp_status(), 32'h2);
    peek(A_BD, d); chk("rst_baud", d, 32'h1B2);
    chk("rst_tx", {31'b0, uart_tx}, 32'h1);
    chk("rst_irq", {31'b0, irq}, 32'h0);

    reg_write(A_BD, 32'h0);
    peek(A_BD, d); chk("baud_clamp", d, m_div);
    reg_write(32'hA000_001C, 32'h9);
    reg_write(A_BD, 32'h4);
    peek(A_BD, d); chk("baud4", d, m_div);
    peek(32'hA000_0018, d); chk("unsel_read", d, 32'h0);
    peek(A_TX, d); chk("txdata_read", d, 32'h0);

    reg_write(A_TX, 32'h55);
    chk("tx_pre", {31'b0, uart_tx}, 32'h1);
    dq = {m_div};
    expect_line('{8'h55}, dq);
    @(negedge coreClk);
    check_status("tx_idle_41");

    exp_bytes = {};
    for (int i = 0; i < 5; i++) model_store(A_TX, 32'h11 + i);
    exp_bytes = m_txq;
    dq = {4, 4, 4, 4};
    fork
      for (int i = 0; i < 5; i++) bus_write(A_TX, 32'h11 + i);
      begin @(negedge coreClk); expect_line(exp_bytes, dq); end
    join
    @(negedge coreClk);
    check_status("tx_ovf_status");
    reg_write(A_ST, 32'h20);
    check_status("tx_ovf_clear");

    send_serial(8'hA5, 1'b1, m_div);
    chk("rx_irq", {31'b0, irq}, 32'h1);
    check_status("rx_valid");
    rx_read_check("rx_a5");
    chk("rx_irq_drop", {31'b0, irq}, 32'h0);
    rx_read_check("rx_empty_read");

    uart_rx = 1'b0; @(negedge coreClk); uart_rx = 1'b1;
    repeat (12) @(negedge coreClk);
    check_status("rx_glitch");
    chk("rx_glitch_irq", {31'b0, irq}, 32'h0);

    send_serial(8'h3C, 1'b0, m_div);
    repeat (4) @(negedge coreClk);
    check_status("rx_frame_err");
    chk("rx_ferr_irq", {31'b0, irq}, 32'h0);

    for (int i = 0; i < 5; i++) send_serial(8'($urandom), 1'b1, m_div);
    check_status("rx_overrun");
    for (int i = 0; i < 4; i++) rx_read_check("rx_order");
    reg_write(A_ST, 32'h38);
    check_status("flags_clear");

    send_serial(8'($urandom), 1'b1, m_div);
    bus.maddr = A_RX; bus.data2mem = 32'hFF; bus.ioWr = 1'b0; bus.ioRd = 1'b0;
    #1 chk("both_strobe_data", bus.io_rdata, {24'b0, m_rxq[0]});
    @(negedge coreClk);
    bus.ioWr = 1'b1; bus.ioRd = 1'b1;
    chk("both_strobe_nopop", {31'b0, irq}, 32'h1);
    rx_read_check("both_strobe_after");

    for (int it = 0; it < 4; it++) begin
      dv = $urandom_range(2, 6);
      reg_write(A_BD, dv);
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) exp_bytes[i] = 8'($urandom);
      exp_bytes = exp_bytes[0:n-1];
      for (int i = 0; i < n; i++) model_store(A_TX, {24'b0, exp_bytes[i]});
      dq = {};
      for (int i = 0; i < n; i++) dq.push_back(m_div);
      fork
        for (int i = 0; i < n; i++) bus_write(A_TX, {24'b0, exp_bytes[i]});
        begin @(negedge coreClk); expect_line(exp_bytes, dq); end
      join
      @(negedge coreClk);
      check_status("rand_tx_status");
    end

    for (int it = 0; it < 6; it++) begin
      dv = $urandom_range(3, 6);
      reg_write(A_BD, dv);
      send_serial(8'($urandom), 1'b1, m_div);
      chk("rand_rx_irq", {31'b0, irq}, 32'h1);
      rx_read_check("rand_rx_data");
    end

    reg_write(A_BD, 32'h4);
    a = 8'($urandom); b = 8'($urandom);
    model_store(A_TX, {24'b0, a});
    model_store(A_TX, {24'b0, b});
    exp_bytes = m_txq;
    dq = {4, 8};
    model_store(A_BD, 32'h8);
    fork
      begin
        bus_write(A_TX, {24'b0, a});
        bus_write(A_TX, {24'b0, b});
        repeat (8) @(negedge coreClk);
        bus_write(A_BD, 32'h8);
      end
      begin @(negedge coreClk); expect_line(exp_bytes, dq); end
    join
    @(negedge coreClk);
    check_status("div_change_status");

    reg_write(A_TX, 32'hC3);
    repeat (12) @(negedge coreClk);
    coreRst = 1'b1;
    @(negedge coreClk);
    coreRst = 1'b0;
    model_reset();
    chk("midframe_rst_tx", {31'b0, uart_tx}, 32'h1);
    check_status("midframe_rst_status");
    peek(A_BD, d); chk("midframe_rst_baud", d, m_div);
    repeat (20) @(negedge coreClk);
    chk("post_rst_tx_quiet", {31'b0, uart_tx}, 32'h1);
    chk("post_rst_irq", {31'b0, irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
